multdiv_sequencer: RTL

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer_pkg.sv | 25 ++
 rtl/multdiv_sequencer_if.sv | 43 ++++
 rtl/multdiv_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM states, status codes,
// and the size and limit of the watchdog counter that guards against a stuck core.
package multdiv_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 6;

    localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT   = 6'd63;
    localparam logic [DATA_W-1:0] STATUS_MULT_EXC = 32'd4;
    localparam logic [DATA_W-1:0] STATUS_DIV_EXC  = 32'd5;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        DRAIN
    } seqState_t;

    function automatic logic [DATA_W-1:0] excStatus(input logic isDivOp);
        return isDivOp ? STATUS_DIV_EXC : STATUS_MULT_EXC;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Pipeline- and core-facing signals of the multdiv sequencer. The sequencer uses
// the slave view; the surrounding pipeline/core (or a bench) uses the master view.
interface multdiv_sequencer_if;
    import multdiv_sequencer_pkg::*;

    logic              is_mult;
    logic              is_div;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [REG_W-1:0]  dest_reg;
    logic              flush;

    logic              core_ready;
    logic [DATA_W-1:0] core_result;
    logic              core_exception;

    logic              ctrl_mult;
    logic              ctrl_div;
    logic [DATA_W-1:0] core_a;
    logic [DATA_W-1:0] core_b;

    logic              multdiv_ready;
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  wb_reg;
    logic              wb_valid;
    logic              status_we;
    logic [DATA_W-1:0] status_value;

    modport slave (
        input  is_mult, is_div, operand_a, operand_b, dest_reg, flush,
        input  core_ready, core_result, core_exception,
        output ctrl_mult, ctrl_div, core_a, core_b,
        output multdiv_ready, result, wb_reg, wb_valid, status_we, status_value
    );

    modport master (
        output is_mult, is_div, operand_a, operand_b, dest_reg, flush,
        output core_ready, core_result, core_exception,
        input  ctrl_mult, ctrl_div, core_a, core_b,
        input  multdiv_ready, result, wb_reg, wb_valid, status_we, status_value
    );

endinterface

// File: rtl/multdiv_sequencer.sv
// Sequences one multiply/divide from the D/X latch through an external multdiv core
// and presents a single-cycle writeback/stall-release pulse, with squash and watchdog.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    multdiv_sequencer_if.slave  bus
);

    seqState_t         state;
    logic [DATA_W-1:0] latA;
    logic [DATA_W-1:0] latB;
    logic [REG_W-1:0]  latDest;
    logic              latIsDiv;
    logic [CNT_W-1:0]  waitCnt;
    logic              timeoutHit;
    logic              finishOp;
    logic              finishExc;

    // Saturating compare so a drain that inherits a nearly expired count still exits.
    assign timeoutHit = waitCnt >= (TIMEOUT_LIMIT - CNT_W'(1));

    assign bus.core_a = latA;
    assign bus.core_b = latB;
    assign bus.wb_reg = latDest;

    always_comb begin
        finishOp  = 1'b0;
        finishExc = 1'b0;
        case (state)
            ISSUE: begin
                if (!bus.flush && latIsDiv && (latB == '0)) begin
                    finishOp  = 1'b1;
                    finishExc = 1'b1;
                end
            end
            WAIT: begin
                if (!bus.flush) begin
                    if (bus.core_ready) begin
                        finishOp  = 1'b1;
                        finishExc = bus.core_exception;
                    end else if (timeoutHit) begin
                        finishOp  = 1'b1;
                        finishExc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            latA              <= '0;
            latB              <= '0;
            latDest           <= '0;
            latIsDiv          <= 1'b0;
            waitCnt           <= '0;
            bus.ctrl_mult     <= 1'b0;
            bus.ctrl_div      <= 1'b0;
            bus.multdiv_ready <= 1'b0;
            bus.wb_valid      <= 1'b0;
            bus.result        <= '0;
            bus.status_we     <= 1'b0;
            bus.status_value  <= '0;
        end else begin
            bus.ctrl_mult     <= 1'b0;
            bus.ctrl_div      <= 1'b0;
            bus.multdiv_ready <= 1'b0;
            bus.wb_valid      <= 1'b0;
            bus.status_we     <= 1'b0;
            bus.status_value  <= '0;

            if (finishOp) begin
                state             <= DONE;
                bus.multdiv_ready <= 1'b1;
                bus.wb_valid      <= 1'b1;
                bus.result        <= finishExc ? '0 : bus.core_result;
                bus.status_we     <= finishExc;
                bus.status_value  <= finishExc ? excStatus(latIsDiv) : '0;
            end else begin
                case (state)
                    IDLE: begin
                        if ((bus.is_mult || bus.is_div) && !bus.flush) begin
                            latA          <= bus.operand_a;
                            latB          <= bus.operand_b;
                            latDest       <= bus.dest_reg;
                            latIsDiv      <= !bus.is_mult;
                            bus.ctrl_mult <= bus.is_mult;
                            bus.ctrl_div  <= !bus.is_mult && (bus.operand_b != '0);
                            state         <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        waitCnt <= '0;
                        // A squashed divide-by-zero never reached the core, so nothing to drain.
                        if (bus.flush) begin
                            state <= (latIsDiv && (latB == '0)) ? IDLE : DRAIN;
                        end else begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        waitCnt <= waitCnt + CNT_W'(1);
                        if (bus.flush) begin
                            state <= bus.core_ready ? IDLE : DRAIN;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    DRAIN: begin
                        waitCnt <= waitCnt + CNT_W'(1);
                        if (bus.core_ready || timeoutHit) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
